// File: rtl/m_fifo_unpacker.sv
// Pops words from a show-ahead FIFO and serializes each into RATIO chunks on a
// valid/ready stream, reloading on the last chunk so consecutive words have no bubble.
module m_fifo_unpacker #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 2,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_pop_data,
  output logic                 fifo_pop_enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if ((RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_params
    $error("m_fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with at least two chunks");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q;
  logic [IN_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;

  logic fire;
  logic last_chunk;

  assign fire       = out_valid & out_ready;
  assign last_chunk = (cnt_q == CNT_LAST);

  // Pop whenever no chunk of the current word would be left unsent after this edge.
  assign fifo_pop_enable = !rst && !fifo_empty &&
                           ((state_q == IDLE) || (fire && last_chunk));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop_enable) begin
            shift_q <= fifo_pop_data;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (!last_chunk) begin
              shift_q <= LSB_FIRST ? (shift_q >> OUT_WIDTH) : (shift_q << OUT_WIDTH);
              cnt_q   <= cnt_q + CNT_W'(1);
            end else if (fifo_pop_enable) begin
              shift_q <= fifo_pop_data;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = (state_q == SEND) && last_chunk;

  if (LSB_FIRST) begin : g_lsb_first
    assign out_data = shift_q[OUT_WIDTH-1:0];
  end else begin : g_msb_first
    assign out_data = shift_q[IN_WIDTH-1 -: OUT_WIDTH];
  end

  a_no_pop_on_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_pop_enable && fifo_empty));

  a_valid_not_withdrawn: assert property (@(posedge clk) disable iff (rst)
    $fell(out_valid) |-> ($past(fire) || $past(rst)));

endmodule

// File: tb/tb_m_fifo_unpacker.sv
// Scoreboard bench: an LSB-first and an MSB-first unpacker share one FIFO model;
// popped words are expanded into expected chunk queues that a monitor drains.
module tb_m_fifo_unpacker;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 2;
  localparam int unsigned R     = IN_W / OUT_W;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             last;
  } chunk_t;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic [IN_W-1:0]  fifo_pop_data;
  logic             out_ready;
  logic             pop0, pop1;
  logic             valid0, valid1;
  logic [OUT_W-1:0] data0, data1;
  logic             last0, last1;
  logic             busy0, busy1;

  m_fifo_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop_data(fifo_pop_data),
    .fifo_pop_enable(pop0), .out_valid(valid0), .out_ready(out_ready),
    .out_data(data0), .out_last(last0), .busy(busy0)
  );

  m_fifo_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop_data(fifo_pop_data),
    .fifo_pop_enable(pop1), .out_valid(valid1), .out_ready(out_ready),
    .out_data(data1), .out_last(last1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [IN_W-1:0] fifo_q[$];
  chunk_t          exp0[$];
  chunk_t          exp1[$];

  int  ready_mode = 0;
  bit  rst_req    = 1'b1;
  bit  hide       = 1'b0;
  int  pat_idx    = 0;
  bit  pat[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Word-to-chunk reference: chunk i is bit field i counted from the chosen end.
  task automatic expand(input logic [IN_W-1:0] w);
    chunk_t c;
    for (int i = 0; i < int'(R); i++) begin
      c.last = (i == int'(R) - 1);
      c.d    = OUT_W'((w >> (i * OUT_W)) & ((1 << OUT_W) - 1));
      exp0.push_back(c);
      c.d    = OUT_W'((w >> ((int'(R) - 1 - i) * OUT_W)) & ((1 << OUT_W) - 1));
      exp1.push_back(c);
    end
  endtask

  // One clock of stimulus: drive at negedge, judge the pop decision once settled.
  task automatic cycle();
    logic exp_pop;
    @(negedge clk);
    rst           = rst_req;
    fifo_empty    = hide || (fifo_q.size() == 0);
    fifo_pop_data = (fifo_q.size() != 0) ? fifo_q[0] : IN_W'($urandom);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = pat[pat_idx % 4];
        pat_idx++;
      end
    endcase
    if (rst_req) out_ready = 1'b0;
    #2;
    exp_pop = !rst && !fifo_empty && (exp0.size() == 0);
    chk("pop_enable_lsb", 32'(pop0), 32'(exp_pop));
    chk("pop_enable_msb", 32'(pop1), 32'(exp_pop));
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end else if (pop0 && !fifo_empty) begin
      expand(fifo_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp0.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  // Monitor: outputs must track the outstanding-chunk queues every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("valid_lsb", 32'(valid0), 32'(exp0.size() != 0));
      chk("busy_lsb",  32'(busy0),  32'(exp0.size() != 0));
      chk("valid_msb", 32'(valid1), 32'(exp1.size() != 0));
      if (valid0 && exp0.size() != 0) begin
        chk("data_lsb", 32'(data0), 32'(exp0[0].d));
        chk("last_lsb", 32'(last0), 32'(exp0[0].last));
        if (out_ready) void'(exp0.pop_front());
      end
      if (valid1 && exp1.size() != 0) begin
        chk("data_msb", 32'(data1), 32'(exp1[0].d));
        chk("last_msb", 32'(last1), 32'(exp1[0].last));
        if (out_ready) void'(exp1.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst           = 1'b1;
    fifo_empty    = 1'b1;
    fifo_pop_data = '0;
    out_ready     = 1'b0;

    // Reset with a non-empty FIFO: no pop, outputs cleared.
    fifo_q.push_back(8'hB4);
    rst_req = 1'b1;
    cycle();
    cycle();
    @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid0), 32'd0);
    chk("reset_last",  32'(last0),  32'd0);
    chk("reset_busy",  32'(busy0),  32'd0);
    chk("reset_data",  32'(data0),  32'd0);
    chk("reset_data_msb", 32'(data1), 32'd0);

    // Single word, then back-to-back words, ready held high.
    rst_req    = 1'b0;
    ready_mode = 0;
    drain(20);
    cycle();
    fifo_q.push_back(8'hB4);
    fifo_q.push_back(8'h1E);
    drain(30);
    cycle();

    // Backpressure pattern on two words.
    ready_mode = 2;
    fifo_q.push_back(8'hC9);
    fifo_q.push_back(8'h5A);
    drain(60);
    cycle();

    // Reset after two of four chunks; the following word starts clean.
    ready_mode = 0;
    fifo_q.push_back(8'hB4);
    fifo_q.push_back(8'h1E);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(exp0.size() == 2 && fifo_q.size() == 1) && n < 20);
    chk("midword_reach", 32'(n < 20), 32'd1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    drain(30);
    cycle();

    // Randomized traffic, random readiness and FIFO underflow gaps.
    ready_mode = 1;
    for (int i = 0; i < 800; i++) begin
      if (($urandom % 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(IN_W'($urandom));
      hide = (($urandom % 4) == 0);
      cycle();
    end
    hide = 1'b0;
    drain(200);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
